aes_word_bridge: RTL and testbench

Responder for the 16-bit word strobe interface used by the AES read/encrypt/write test engine. It serializes host-supplied 128-bit blocks into a read-word FIFO that the engine drains with `read`/`readdata`. It also collects the engine's `write`/`writedata` words into a write-word FIFO and reassembles them into 128-bit result blocks for the host. It drives the `ReadUse`/`WriteUse` fill counts and the `SDRAM_read`/`SDRAM_write` busy flags that the engine polls before each access.

---
 rtl/aes_word_bridge.sv | 188 ++++++++++++++++++
 tb/tb_aes_word_bridge.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_word_bridge.sv
// Word-strobe responder: 128-bit host blocks in/out <-> 16-bit engine words via two FIFOs.
// Block-to-word latency 1-8 cycles, words-to-block 10 cycles; in_ready needs 8 free words, result held until out_ready.
module aes_word_bridge #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int USE_W  = 16
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [127:0]      in_block,
  input  logic              read,
  output logic [DATA_W-1:0] readdata,
  output logic [USE_W-1:0]  ReadUse,
  output logic              SDRAM_read,
  input  logic              write,
  input  logic [DATA_W-1:0] writedata,
  output logic [USE_W-1:0]  WriteUse,
  output logic              SDRAM_write,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [127:0]      out_block,
  output logic [1:0]        err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {SER_IDLE, SER_PUSH} ser_state_t;
  typedef enum logic [1:0] {DES_IDLE, DES_POP, DES_CAP, DES_HOLD} des_state_t;

  ser_state_t        ser_state_q, ser_state_d;
  logic [127:0]      ser_blk_q, ser_blk_d;
  logic [2:0]        ser_k_q, ser_k_d;
  logic              sdram_read_q, sdram_read_d;

  logic [DATA_W-1:0] rd_mem_q [DEPTH];
  logic [AW-1:0]     rd_wptr_q, rd_wptr_d, rd_rptr_q, rd_rptr_d;
  logic [CW-1:0]     rd_cnt_q, rd_cnt_d;
  logic [DATA_W-1:0] readdata_q, readdata_d;
  logic              rd_push, rd_pop;
  logic [DATA_W-1:0] rd_push_dat;

  logic [DATA_W-1:0] wr_mem_q [DEPTH];
  logic [AW-1:0]     wr_wptr_q, wr_wptr_d, wr_rptr_q, wr_rptr_d;
  logic [CW-1:0]     wr_cnt_q, wr_cnt_d;
  logic              wr_push, wr_pop, wr_full;

  des_state_t        des_state_q, des_state_d;
  logic [2:0]        des_k_q, des_k_d;
  logic              cap_vld_q, cap_vld_d;
  logic [2:0]        cap_idx_q, cap_idx_d;
  logic [DATA_W-1:0] cap_dat_q, cap_dat_d;
  logic [127:0]      out_block_q, out_block_d;
  logic              out_valid_q, out_valid_d;
  logic              sdram_write_q, sdram_write_d;
  logic [1:0]        err_q, err_d;

  // Only a fully idle serializer with room for a whole block may accept.
  assign in_ready = (ser_state_q == SER_IDLE) && (rd_cnt_q <= CW'(DEPTH - 8));

  always_comb begin
    ser_state_d = ser_state_q;
    ser_blk_d   = ser_blk_q;
    ser_k_d     = ser_k_q;
    case (ser_state_q)
      SER_IDLE: begin
        if (in_valid && in_ready) begin
          ser_blk_d   = in_block;
          ser_k_d     = 3'd0;
          ser_state_d = SER_PUSH;
        end
      end
      SER_PUSH: begin
        ser_k_d = ser_k_q + 3'd1;
        if (ser_k_q == 3'd7) ser_state_d = SER_IDLE;
      end
      default: ser_state_d = SER_IDLE;
    endcase
    sdram_read_d = (ser_state_d == SER_PUSH);

    rd_push     = (ser_state_q == SER_PUSH);
    rd_push_dat = ser_blk_q[{ser_k_q, 4'b0000} +: DATA_W];
    rd_pop      = read && (rd_cnt_q != '0);
    rd_wptr_d   = rd_wptr_q + AW'(rd_push);
    rd_rptr_d   = rd_rptr_q + AW'(rd_pop);
    rd_cnt_d    = rd_cnt_q + CW'(rd_push) - CW'(rd_pop);
    readdata_d  = rd_pop ? rd_mem_q[rd_rptr_q] : readdata_q;

    wr_full   = (wr_cnt_q == CW'(DEPTH));
    wr_push   = write && !wr_full;
    wr_pop    = (des_state_q == DES_POP);
    wr_wptr_d = wr_wptr_q + AW'(wr_push);
    wr_rptr_d = wr_rptr_q + AW'(wr_pop);
    wr_cnt_d  = wr_cnt_q + CW'(wr_push) - CW'(wr_pop);

    des_state_d = des_state_q;
    des_k_d     = des_k_q;
    case (des_state_q)
      DES_IDLE: begin
        if (wr_cnt_q >= CW'(8)) begin
          des_state_d = DES_POP;
          des_k_d     = 3'd0;
        end
      end
      DES_POP: begin
        des_k_d = des_k_q + 3'd1;
        if (des_k_q == 3'd7) des_state_d = DES_CAP;
      end
      DES_CAP:  des_state_d = DES_HOLD;
      DES_HOLD: if (out_ready) des_state_d = DES_IDLE;
      default:  des_state_d = DES_IDLE;
    endcase

    // Popped word is staged one cycle, then placed into its lane of the result.
    cap_vld_d   = wr_pop;
    cap_idx_d   = des_k_q;
    cap_dat_d   = wr_mem_q[wr_rptr_q];
    out_block_d = out_block_q;
    if (cap_vld_q) out_block_d[{cap_idx_q, 4'b0000} +: DATA_W] = cap_dat_q;

    out_valid_d   = (des_state_d == DES_HOLD);
    sdram_write_d = (des_state_d == DES_POP) || (des_state_d == DES_CAP);
    err_d         = err_q | {write && wr_full, read && (rd_cnt_q == '0)};
  end

  always_ff @(posedge iCLK) begin
    if (rd_push) rd_mem_q[rd_wptr_q] <= rd_push_dat;
    if (wr_push) wr_mem_q[wr_wptr_q] <= writedata;
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      ser_state_q   <= SER_IDLE;
      ser_blk_q     <= '0;
      ser_k_q       <= '0;
      sdram_read_q  <= 1'b0;
      rd_wptr_q     <= '0;
      rd_rptr_q     <= '0;
      rd_cnt_q      <= '0;
      readdata_q    <= '0;
      wr_wptr_q     <= '0;
      wr_rptr_q     <= '0;
      wr_cnt_q      <= '0;
      des_state_q   <= DES_IDLE;
      des_k_q       <= '0;
      cap_vld_q     <= 1'b0;
      cap_idx_q     <= '0;
      cap_dat_q     <= '0;
      out_block_q   <= '0;
      out_valid_q   <= 1'b0;
      sdram_write_q <= 1'b0;
      err_q         <= '0;
    end else begin
      ser_state_q   <= ser_state_d;
      ser_blk_q     <= ser_blk_d;
      ser_k_q       <= ser_k_d;
      sdram_read_q  <= sdram_read_d;
      rd_wptr_q     <= rd_wptr_d;
      rd_rptr_q     <= rd_rptr_d;
      rd_cnt_q      <= rd_cnt_d;
      readdata_q    <= readdata_d;
      wr_wptr_q     <= wr_wptr_d;
      wr_rptr_q     <= wr_rptr_d;
      wr_cnt_q      <= wr_cnt_d;
      des_state_q   <= des_state_d;
      des_k_q       <= des_k_d;
      cap_vld_q     <= cap_vld_d;
      cap_idx_q     <= cap_idx_d;
      cap_dat_q     <= cap_dat_d;
      out_block_q   <= out_block_d;
      out_valid_q   <= out_valid_d;
      sdram_write_q <= sdram_write_d;
      err_q         <= err_d;
    end
  end

  assign readdata    = readdata_q;
  assign ReadUse     = USE_W'(rd_cnt_q);
  assign WriteUse    = USE_W'(wr_cnt_q);
  assign SDRAM_read  = sdram_read_q;
  assign SDRAM_write = sdram_write_q;
  assign out_valid   = out_valid_q;
  assign out_block   = out_block_q;
  assign err         = err_q;

endmodule

// File: tb/tb_aes_word_bridge.sv
// Directed bench for aes_word_bridge: serializer, deserializer, error flags, back-to-back blocks, mid-block reset.
module tb_aes_word_bridge;

  logic         iCLK = 1'b0;
  logic         iRST;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_block;
  logic         read;
  logic [15:0]  readdata;
  logic [15:0]  ReadUse;
  logic         SDRAM_read;
  logic         write;
  logic [15:0]  writedata;
  logic [15:0]  WriteUse;
  logic         SDRAM_write;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_block;
  logic [1:0]   err;

  int tests = 0;
  int fails = 0;

  aes_word_bridge #(.DATA_W(16), .DEPTH(16), .USE_W(16)) dut (
    .iCLK(iCLK), .iRST(iRST),
    .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block),
    .read(read), .readdata(readdata), .ReadUse(ReadUse), .SDRAM_read(SDRAM_read),
    .write(write), .writedata(writedata), .WriteUse(WriteUse), .SDRAM_write(SDRAM_write),
    .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block), .err(err)
  );

  always #5 iCLK = ~iCLK;

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mk_block(input logic [15:0] base);
    logic [127:0] b;
    for (int k = 0; k < 8; k++) b[16*k +: 16] = base + 16'(k);
    return b;
  endfunction

  task automatic write_words(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      write = 1'b1;
      writedata = base + 16'(i);
      tick();
    end
    write = 1'b0;
  endtask

  task automatic wait_out_valid(input string tag);
    int n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    chk(tag, out_valid, 1'b1);
  endtask

  logic [127:0] got;

  initial begin
    iRST = 1'b1; in_valid = 1'b0; in_block = '0; read = 1'b0;
    write = 1'b0; writedata = '0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_readdata", readdata, 16'h0);
    chk("rst_readuse", ReadUse, 16'd0);
    chk("rst_writeuse", WriteUse, 16'd0);
    chk("rst_outvalid", out_valid, 1'b0);
    chk("rst_outblock", out_block, 128'h0);
    chk("rst_flags", {SDRAM_read, SDRAM_write, err}, 4'b0000);
    iRST = 1'b0;
    tick();
    chk("rst_inready", in_ready, 1'b1);

    // Serialize one block: word k = k
    in_block = mk_block(16'h0000);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("ser_busy", {in_ready, SDRAM_read}, 2'b01);
    chk("ser_use0", ReadUse, 16'd0);
    tick();
    chk("ser_use1", ReadUse, 16'd1);
    for (int i = 0; i < 6; i++) tick();
    chk("ser_use7", {SDRAM_read, ReadUse}, {1'b1, 16'd7});
    tick();
    chk("ser_use8", {SDRAM_read, ReadUse}, {1'b0, 16'd8});
    chk("ser_ready_again", in_ready, 1'b1);
    for (int k = 0; k < 8; k++) begin
      read = 1'b1;
      tick();
      read = 1'b0;
      chk($sformatf("rd_word%0d", k), readdata, 16'(k));
      tick();
    end
    chk("rd_empty", ReadUse, 16'd0);

    // Underflow
    read = 1'b1;
    tick();
    read = 1'b0;
    chk("uf_readdata", readdata, 16'h0007);
    chk("uf_err", err, 2'b01);
    chk("uf_use", ReadUse, 16'd0);

    // Deserialize one block
    write_words(16'hA000, 8);
    chk("des_wuse8", WriteUse, 16'd8);
    tick();
    chk("des_busy", {SDRAM_write, out_valid}, 2'b10);
    for (int i = 0; i < 8; i++) tick();
    chk("des_drained", {SDRAM_write, out_valid, WriteUse}, {2'b10, 16'd0});
    tick();
    chk("des_valid", {SDRAM_write, out_valid}, 2'b01);
    chk("des_block", out_block, mk_block(16'hA000));
    for (int i = 0; i < 20; i++) tick();
    chk("des_hold", {out_valid, out_block}, {1'b1, mk_block(16'hA000)});

    // Overflow while the held block blocks draining
    write_words(16'hB000, 16);
    chk("of_full", {err, WriteUse}, {2'b01, 16'd16});
    write_words(16'hB010, 1);
    chk("of_drop", {err, WriteUse}, {2'b11, 16'd16});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("of_release", out_valid, 1'b0);
    wait_out_valid("of_wait1");
    chk("of_block1", out_block, mk_block(16'hB000));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    wait_out_valid("of_wait2");
    chk("of_block2", out_block, mk_block(16'hB008));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    chk("of_dropped_gone", {out_valid, WriteUse}, {1'b0, 16'd0});

    // Back-to-back host blocks
    in_block = mk_block(16'h1000);
    in_valid = 1'b1;
    tick();
    in_block = mk_block(16'h2000);
    for (int i = 0; i < 8; i++) tick();
    chk("b2b_ready2", {in_ready, ReadUse}, {1'b1, 16'd8});
    tick();
    in_block = mk_block(16'h3000);
    chk("b2b_busy2", SDRAM_read, 1'b1);
    for (int i = 0; i < 8; i++) tick();
    chk("b2b_full", {in_ready, ReadUse}, {1'b0, 16'd16});
    tick(); tick(); tick();
    chk("b2b_wait", {in_ready, SDRAM_read, ReadUse}, {2'b00, 16'd16});
    read = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      got[16*k +: 16] = readdata;
      if (k == 6) chk("b2b_ready_after7", in_ready, 1'b0);
    end
    read = 1'b0;
    chk("b2b_blockA", got, mk_block(16'h1000));
    chk("b2b_ready_after8", {in_ready, ReadUse}, {1'b1, 16'd8});
    tick();
    in_valid = 1'b0;
    chk("b2b_accept3", SDRAM_read, 1'b1);
    for (int i = 0; i < 8; i++) tick();
    chk("b2b_use16", ReadUse, 16'd16);
    read = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      got[16*k +: 16] = readdata;
    end
    chk("b2b_blockB", got, mk_block(16'h2000));
    for (int k = 0; k < 8; k++) begin
      tick();
      got[16*k +: 16] = readdata;
    end
    read = 1'b0;
    chk("b2b_blockC", got, mk_block(16'h3000));
    chk("b2b_empty", ReadUse, 16'd0);

    // Reset in the middle of serialization
    in_block = mk_block(16'h4000);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("rs_ser_mid", {SDRAM_read, ReadUse}, {1'b1, 16'd4});
    iRST = 1'b1;
    tick();
    iRST = 1'b0;
    chk("rs_ser_clear", {SDRAM_read, ReadUse, readdata, err}, {1'b0, 16'd0, 16'd0, 2'b00});
    chk("rs_ser_ready", in_ready, 1'b1);

    // Reset in the middle of deserialization
    write_words(16'h5000, 8);
    tick(); tick(); tick();
    chk("rs_des_mid", SDRAM_write, 1'b1);
    iRST = 1'b1;
    tick();
    iRST = 1'b0;
    chk("rs_des_clear", {SDRAM_write, out_valid, WriteUse, out_block}, {2'b00, 16'd0, 128'h0});
    for (int i = 0; i < 12; i++) tick();
    chk("rs_no_partial", {out_valid, SDRAM_write, WriteUse}, {2'b00, 16'd0});

    // Fresh traffic after reset
    in_block = mk_block(16'h6000);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("fr_use8", ReadUse, 16'd8);
    read = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      got[16*k +: 16] = readdata;
    end
    read = 1'b0;
    chk("fr_read_block", got, mk_block(16'h6000));
    write_words(16'h7000, 8);
    wait_out_valid("fr_wait");
    chk("fr_out_block", out_block, mk_block(16'h7000));
    chk("fr_err", err, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
